// File: rtl/mel_log_module.sv
// mel_log_module: natural log of an unsigned fixed-point mel energy, output as signed INT16 Q11.
// Sits between the mel filterbank and the DCT of the MFCC front end.
//
// Algorithm: normalise to m in [1,2) with integer exponent, extract Q_L fraction bits of log2(m)
// by repeated squaring (one bit per cycle), then scale log2 -> ln by ln2 (Q15) with
// round-half-up and saturation.
//
// Ports:
//   clk          clock, all logic posedge
//   rst          asynchronous active-high reset
//   energy_in    unsigned energy, Q(32-IN_Q).IN_Q
//   energy_valid energy_in valid; captured only while in_ready=1
//   in_ready     block idle, accepts a sample
//   log_out      signed ln(energy), Q(Q_L); held until the next log_valid
//   log_valid    one-cycle strobe for log_out
//   frame_last   high with the log_valid of band N_BANDS-1
//
// Build option: define MEL_LOG_FLOOR_EN to clamp results (including zero input) at LOG_FLOOR.
module mel_log_module #(
  parameter int unsigned        IN_Q      = 16,
  parameter int unsigned        Q_L       = 11,
  parameter int unsigned        N_BANDS   = 32,
  parameter logic signed [15:0] LOG_FLOOR = -16'sd8192
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        energy_in,
  input  logic               energy_valid,
  output logic               in_ready,
  output logic signed [15:0] log_out,
  output logic               log_valid,
  output logic               frame_last
);

  localparam int unsigned        CntW    = (Q_L > 1) ? $clog2(Q_L) : 1;
  localparam int unsigned        BandW   = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam int unsigned        L2W     = 6 + Q_L;
  localparam int unsigned        ProdW   = L2W + 17;
  localparam logic signed [15:0] Ln2Q15  = 16'sh58B9;
  localparam logic [BandW-1:0]   LastBand = BandW'(N_BANDS - 1);

  typedef enum logic [1:0] {StIdle, StNorm, StFrac, StScale} state_e;

  state_e state_q, state_d;

  logic [31:0]        energy_q;
  logic signed [5:0]  int_q;
  logic [15:0]        m_q;
  logic               zero_q;
  logic [Q_L-1:0]     frac_q;
  logic [CntW-1:0]    cnt_q;
  logic [BandW-1:0]   band_q;
  logic signed [15:0] log_out_q;
  logic               log_valid_q;
  logic               frame_last_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (energy_valid) state_d = StNorm;
      StNorm:  state_d = StFrac;
      StFrac:  if (cnt_q == '0) state_d = StScale;
      StScale: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == StIdle);
  end

  // Normalisation: MSB position gives the integer part of log2
  logic [4:0]        msb_pos;
  logic signed [5:0] int_d;
  logic [31:0]       shifted;
  logic [15:0]       m_norm;

  always_comb begin
    msb_pos = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (energy_q[i]) msb_pos = 5'(i);
    end
    int_d   = $signed({1'b0, msb_pos}) - $signed(6'(IN_Q));
    shifted = energy_q << (5'd31 - msb_pos);
    m_norm  = 16'(shifted >> 16);
  end

  // Fraction step: m^2 >= 2 emits a 1 and renormalises by 2, else emits a 0
  logic [31:0] sq;
  logic [15:0] m_next;

  always_comb begin
    sq     = 32'(m_q) * 32'(m_q);
    m_next = sq[31] ? 16'(sq >> 16) : 16'(sq >> 15);
  end

  // Scale log2 -> ln, round half up, saturate
  logic signed [L2W-1:0]   l2;
  logic signed [ProdW-1:0] prod;
  logic signed [ProdW-1:0] scaled;
  logic signed [15:0]      result;

  always_comb begin
    l2     = {int_q, frac_q};
    prod   = ProdW'(l2) * ProdW'(Ln2Q15) + ProdW'(1 << 14);
    scaled = prod >>> 15;
    if (scaled > ProdW'(32767))       result = 16'sh7FFF;
    else if (scaled < ProdW'(-32768)) result = 16'sh8000;
    else                              result = scaled[15:0];
    if (zero_q) result = 16'sh8000;
`ifdef MEL_LOG_FLOOR_EN
    if (result < LOG_FLOOR) result = LOG_FLOOR;
`endif
  end

  // Datapath and band counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      energy_q     <= '0;
      int_q        <= '0;
      m_q          <= '0;
      zero_q       <= 1'b0;
      frac_q       <= '0;
      cnt_q        <= '0;
      band_q       <= '0;
      log_out_q    <= '0;
      log_valid_q  <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      log_valid_q  <= 1'b0;
      frame_last_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (energy_valid) energy_q <= energy_in;
        end
        StNorm: begin
          int_q  <= int_d;
          m_q    <= m_norm;
          zero_q <= (energy_q == '0);
          frac_q <= '0;
          cnt_q  <= CntW'(Q_L - 1);
        end
        StFrac: begin
          m_q    <= m_next;
          frac_q <= {frac_q[Q_L-2:0], sq[31]};
          cnt_q  <= cnt_q - 1'b1;
        end
        StScale: begin
          log_out_q    <= result;
          log_valid_q  <= 1'b1;
          frame_last_q <= (band_q == LastBand);
          band_q       <= (band_q == LastBand) ? '0 : band_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign log_out    = log_out_q;
  assign log_valid  = log_valid_q;
  assign frame_last = frame_last_q;

endmodule

// File: tb/tb_mel_log_module.sv
// Self-checking bench for mel_log_module: directed vector table, randomised samples against a
// reference model, a streaming run and a mid-computation reset.
module tb_mel_log_module;

  localparam int QL   = 11;
  localparam int INQ  = 16;
  localparam int NB   = 32;
  localparam int LAT  = QL + 2;
  localparam int PER  = QL + 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [31:0]        energy_in = '0;
  logic               energy_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] log_out;
  logic               log_valid;
  logic               frame_last;

  int errors = 0;
  int checks = 0;
  int band_model = 0;

  mel_log_module dut (
    .clk         (clk),
    .rst         (rst),
    .energy_in   (energy_in),
    .energy_valid(energy_valid),
    .in_ready    (in_ready),
    .log_out     (log_out),
    .log_valid   (log_valid),
    .frame_last  (frame_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] e;
    int          exp;
    int          tol;
    string       name;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp, input longint tol);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, got, exp, tol);
    end
  endtask

  // Reference: log2 by normalise + repeated squaring, then ln = round(log2 * ln2_q15 / 2^15)
  function automatic int model(input logic [31:0] x);
    longint m, sq, frac, l2, t;
    int p;
    int res;
    if (x == 0) begin
      res = -32768;
    end else begin
      p = 31;
      while (x[p] == 1'b0) p--;
      if (p >= 15) m = longint'(x) >> (p - 15);
      else         m = longint'(x) << (15 - p);
      frac = 0;
      for (int i = 0; i < QL; i++) begin
        sq   = m * m;
        frac = frac * 2;
        if (sq >= 64'h8000_0000) begin
          frac = frac + 1;
          m    = sq >> 16;
        end else begin
          m = sq >> 15;
        end
      end
      l2 = longint'(p - INQ) * (1 << QL) + frac;
      t  = (l2 * 22713 + 16384) >>> 15;
      if (t > 32767)       res = 32767;
      else if (t < -32768) res = -32768;
      else                 res = int'(t);
    end
`ifdef MEL_LOG_FLOOR_EN
    if (res < -8192) res = -8192;
`endif
    return res;
  endfunction

  // Present one sample, wait for its result; checks latency, busy in_ready and frame_last
  task automatic send(input string name, input logic [31:0] e, input int exp, input int tol);
    int waitn;
    int lat;
    int busy_hi;
    waitn = 0;
    @(negedge clk);
    while (!in_ready && waitn < 50) begin
      @(negedge clk);
      waitn++;
    end
    if (!in_ready) begin
      chk({name, "_ready_timeout"}, 0, 1, 0);
      return;
    end
    energy_in    = e;
    energy_valid = 1'b1;
    @(posedge clk);
    #1 energy_valid = 1'b0;
    lat     = 0;
    busy_hi = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (log_valid) break;
      if (in_ready) busy_hi++;
    end
    chk({name, "_latency"}, lat, LAT, 0);
    chk({name, "_busy_ready"}, busy_hi, 0, 0);
    if (log_valid) begin
      chk({name, "_value"}, log_out, exp, tol);
      chk({name, "_frame_last"}, frame_last, (band_model == NB - 1) ? 1 : 0, 0);
      band_model = (band_model + 1) % NB;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1, 0);
    chk("rst_log_out", log_out, 0, 0);
    chk("rst_log_valid", log_valid, 0, 0);
    chk("rst_frame_last", frame_last, 0, 0);
    energy_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    band_model = 0;
  endtask

  vec_t        vecs[6];
  logic [31:0] samp[0:64*PER-1];
  logic [31:0] e;

  initial begin
    int pulses, last_k, extra;

    vecs[0] = '{32'h0001_0000, 0, 0, "one"};
    vecs[1] = '{32'h0002_0000, 1420, 0, "two"};
`ifdef MEL_LOG_FLOOR_EN
    vecs[2] = '{32'h0000_0001, -8192, 0, "min_lsb"};
    vecs[3] = '{32'h0000_0000, -8192, 0, "zero"};
`else
    vecs[2] = '{32'h0000_0001, -22713, 0, "min_lsb"};
    vecs[3] = '{32'h0000_0000, -32768, 0, "zero"};
`endif
    vecs[4] = '{32'hFFFF_FFFF, 22712, 1, "max"};
    vecs[5] = '{32'h0000_8000, -1420, 0, "half"};

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("por_in_ready", in_ready, 1, 0);
    chk("por_log_out", log_out, 0, 0);
    chk("por_log_valid", log_valid, 0, 0);
    chk("por_frame_last", frame_last, 0, 0);
    @(negedge clk) rst = 1'b0;

    // Directed vectors
    foreach (vecs[i]) send(vecs[i].name, vecs[i].e, vecs[i].exp, vecs[i].tol);

    // Randomised samples against the model, spread across magnitudes
    for (int i = 0; i < 40; i++) begin
      e = $urandom >> $urandom_range(0, 31);
      send("rand", e, model(e), 0);
    end

    // Stream with energy_valid held high; only every PER-th sample is captured
    do_reset();
    for (int k = 0; k < 64 * PER; k++) samp[k] = $urandom >> $urandom_range(0, 24);
    pulses = 0;
    last_k = -1;
    for (int k = 0; k < 64 * PER; k++) begin
      @(negedge clk);
      energy_in    = samp[k];
      energy_valid = 1'b1;
      @(posedge clk);
      #1;
      if (log_valid) begin
        pulses++;
        chk("stream_phase", k % PER, LAT, 0);
        if (k >= LAT) chk("stream_value", log_out, model(samp[k - LAT]), 0);
        chk("stream_frame_last", frame_last, (pulses % NB == 0) ? 1 : 0, 0);
        if (last_k >= 0) chk("stream_spacing", k - last_k, PER, 0);
        last_k = k;
      end
    end
    @(negedge clk) energy_valid = 1'b0;
    extra = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (log_valid) extra++;
    end
    chk("stream_pulse_count", pulses, 64, 0);
    chk("stream_no_extra", extra, 0, 0);
    band_model = 0;

    // Advance the band counter, then reset 5 cycles into FRAC
    for (int i = 0; i < 5; i++) begin
      e = $urandom;
      send("pre_rst", e, model(e), 0);
    end
    @(negedge clk);
    energy_in    = 32'h0123_4567;
    energy_valid = 1'b1;
    @(posedge clk);
    #1 energy_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_early_valid", log_valid, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1, 0);
    chk("midrst_log_out", log_out, 0, 0);
    chk("midrst_log_valid", log_valid, 0, 0);
    chk("midrst_frame_last", frame_last, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    band_model = 0;
    extra = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (log_valid) extra++;
    end
    chk("midrst_dropped", extra, 0, 0);
    for (int i = 0; i < NB; i++) begin
      e = $urandom >> $urandom_range(0, 31);
      send("post_rst", e, model(e), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // log_valid must never be high in two consecutive cycles
  logic lv_prev = 1'b0;
  always @(negedge clk) begin
    if (log_valid && lv_prev) begin
      errors++;
      $display("FAIL log_valid_double: got 1 on consecutive cycles, expected single-cycle strobe");
    end
    lv_prev <= log_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mel_log_module.md
# mel_log_module

Converts each unsigned fixed-point mel filterbank energy to its natural logarithm in signed INT16 Q11. It sits between the mel filterbank and the DCT stage of the MFCC front end. Its serial `log_out`/`log_valid` stream drives the DCT's `data_in`/`data_valid` directly. It also flags the last band of each frame so downstream logic can check frame alignment.

## Interface
- `IN_Q`, 16: fractional bits of the input energy (unsigned Q(32-IN_Q).IN_Q).
- `Q_L`, 11: fractional bits of the output log; also the number of iterative fraction cycles.
- `N_BANDS`, 32: mel bands per frame; must match the DCT's N.
- `LOG_FLOOR`, -16'sd8192: lower clamp on the output (-4.0 in Q11); used only with `MEL_LOG_FLOOR_EN`.
- `clk` input 1: single clock; all logic is posedge.
- `rst` input 1: asynchronous, active-high reset.
- `energy_in` input 32: unsigned mel energy.
- `energy_valid` input 1: `energy_in` is valid.
- `in_ready` output 1: block is idle and accepts a sample.
- `log_out` output 16: signed ln(energy), Q11.
- `log_valid` output 1: one-cycle strobe; `log_out` is valid.
- `frame_last` output 1: high with the `log_valid` of band N_BANDS-1.

## Operation
- Reset values:
  - `in_ready`=1, `log_out`=0, `log_valid`=0, `frame_last`=0.
  - State IDLE, band counter 0, all datapath registers 0.
- The FSM has four states: IDLE, NORM, FRAC, SCALE.
- IDLE:
  - `in_ready`=1.
  - On `energy_valid`, capture `energy_in` and go to NORM.
  - `energy_valid` while `in_ready`=0 is ignored; upstream must hold or retry.
- NORM (1 cycle):
  - Priority-encode the MSB position p (0..31) and record int = p - IN_Q as a signed 6-bit value.
  - Left-justify the input into mantissa m, unsigned Q1.15 in [1,2).
  - For a zero input, set a zero flag; m is don't-care.
- FRAC (Q_L cycles, counter Q_L-1 down to 0), one fraction bit per cycle, MSB first:
  - Compute sq = m*m as a 32-bit Q2.30 value.
  - If sq[31]=1: bit=1 and m=sq[31:16].
  - Otherwise: bit=0 and m=sq[30:15].
  - Results are truncated, not rounded.
- SCALE (1 cycle):
  - L2 = {int, frac}, signed 6+Q_L bits, Q(Q_L).
  - ln = (L2 * 16'sh58B9 + 2^14) >>> 15, where ln2 is in Q15 and the result rounds half up.
  - Saturate to [-32768, 32767].
  - Zero flag forces -32768.
  - Register `log_out`, pulse `log_valid`, and return to IDLE.
- Band counter:
  - Increments on each `log_valid` and wraps N_BANDS-1 to 0.
  - `frame_last` = (counter == N_BANDS-1) and `log_valid`.
- Reset asserted mid-computation discards the partial result. No `log_valid` is produced for it, and the band counter clears.

## Timing
- Acceptance edge is E0; NORM runs E0→E1, FRAC runs E1→E1+Q_L, SCALE runs to E2+Q_L.
- `log_valid` and `log_out` are valid for the single cycle following edge E0+Q_L+2. With the default Q_L, that is 13 edges after acceptance.
- `in_ready` returns to 1 on the same edge `log_valid` rises.
- A sample presented in that cycle is accepted, so sustained throughput is one sample per Q_L+3 cycles (14).
- `log_out` holds its value until the next `log_valid`.
- `log_valid` never stays high for two consecutive cycles, which matches the DCT's one-sample-per-strobe capture.

## Configuration
- `MEL_LOG_FLOOR_EN` defined:
  - After saturation, any result below LOG_FLOOR outputs LOG_FLOOR.
  - This includes zero input, which then outputs LOG_FLOOR instead of -32768.
- `MEL_LOG_FLOOR_EN` undefined:
  - No floor is applied. Zero input outputs -32768, and all other results are the saturated computed value.
  - The LOG_FLOOR parameter is unused.

## Test plan
- Reset and default parameters, `energy_in`=32'h0001_0000 (1.0):
  - `log_out`=0, `log_valid` exactly 13 edges after acceptance.
  - `in_ready` low for the intervening cycles.
- `energy_in`=32'h0002_0000 → `log_out`=1420. `energy_in`=32'h0000_0001 → `log_out`=-22713 (floor off).
- `energy_in`=0:
  - Floor off: `log_out`=-32768.
  - With `MEL_LOG_FLOOR_EN`: `log_out`=-8192. The same build with 32'h0000_0001 also yields -8192.
- `energy_in`=32'hFFFF_FFFF → `log_out`=22712 ±1 LSB (truncation in FRAC).
- Stream 64 samples with `energy_valid` held high:
  - Exactly 64 `log_valid` pulses, spaced 14 cycles apart.
  - `frame_last` on pulses 32 and 64 only.
  - Samples presented while `in_ready`=0 are not captured.
- Assert `rst` 5 cycles into FRAC:
  - Outputs return to reset values immediately; no `log_valid` is produced for that sample.
  - The next frame's `frame_last` falls on its 32nd output.
